mips_reg_dump: RTL and testbench
================================

MIPS_REG_DUMP -- requirements
Module: mips_reg_dump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0: first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have port clk1, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port halted, input, 1 bit: pipeline HALTED flag, set after HLT retires.
REQ-006 SHALL have port rf_rd_en, output, 1 bit: register-file read strobe.
REQ-007 SHALL have port rf_rd_addr, output, 5 bits: register-file read index.
REQ-008 SHALL have port rf_rd_data, input, 32 bits: read data, valid exactly 1 cycle after rf_rd_en.
REQ-009 SHALL have port dout_valid, output, 1 bit: output beat valid.
REQ-010 SHALL have port dout_ready, input, 1 bit: sink accepts beat.
REQ-011 SHALL have port dout_addr, output, 5 bits: register index of the current beat.
REQ-012 SHALL have port dout_data, output, 32 bits: register value of the current beat.
REQ-013 SHALL have port dout_last, output, 1 bit: final beat of the dump.
REQ-014 SHALL have port busy, output, 1 bit: dump in progress.
REQ-015 SHALL have port done, output, 1 bit: dump complete; held until halted falls.

Function
REQ-016 SHALL start a dump on the rising edge of halted (halted=1 while the registered previous value was 0), only from IDLE.
REQ-017 SHALL implement the FSM IDLE->READ->WAIT->SEND->(READ | DONE), with DONE->IDLE when halted=0.
REQ-018 SHALL in READ assert rf_rd_en for exactly one cycle with rf_rd_addr equal to the current index.
REQ-019 SHALL in WAIT capture rf_rd_data into the dout_data register.
REQ-020 SHALL in SEND hold dout_valid=1; a beat transfers when dout_valid and dout_ready are both 1.
REQ-021 SHALL keep dout_addr, dout_data and dout_last stable while dout_valid=1 and dout_ready=0.
REQ-022 SHALL emit indices FIRST_REG..LAST_REG ascending; index increments only on a transfer.
REQ-023 SHALL assert dout_last only on the LAST_REG beat; after that transfer the FSM enters DONE.
REQ-024 SHALL give a first-beat latency of 3 cycles from the halted rising edge to dout_valid; minimum 3 cycles per beat.
REQ-025 SHALL assert busy in READ, WAIT and SEND; SHALL assert done only in DONE.
REQ-026 SHALL complete an in-flight dump even if halted falls mid-dump; SHALL then pass through DONE for one cycle to IDLE.
REQ-027 SHALL ignore further halted edges while busy or in DONE.
REQ-028 SHALL not wrap the index past LAST_REG, including when LAST_REG=31.

Reset
REQ-029 SHALL on rst_n=0 immediately enter IDLE, with all outputs and the halted-edge register at 0.
REQ-030 SHALL on reset during a dump abandon it; the next halted rising edge restarts at FIRST_REG.

Configuration
REQ-031 SHALL, with REG_DUMP_CHECKSUM_EN defined, XOR-accumulate all dumped words and append one extra beat after LAST_REG: dout_data = checksum, dout_addr = 0, plus a dout_csum output (1 on that beat only); dout_last moves to this beat.
REQ-032 SHALL, without REG_DUMP_CHECKSUM_EN, contain no dout_csum port, no accumulator and no extra beat.

Structure
REQ-033 SHALL take the FSM state type, REG_ADDR_W=5 and WORD_W=32 from the shared package mips_dbg_pkg.
REQ-034 SHALL be a single module with no sub-modules; the checksum accumulator is inline.

Verification
REQ-035 SHALL cover a full dump: Reg[k]=k*3, halted 0->1, dout_ready=1 -> 32 beats, addr 0..31, data 0,3,...,93, dout_last on addr 31, then done=1.
REQ-036 SHALL cover backpressure: dout_ready=0 for 5 cycles at beat addr 7 -> dout_valid stays 1, addr=7, data=21 stable; no skipped or duplicated beat.
REQ-037 SHALL cover reset mid-dump: rst_n=0 at beat 10 -> all outputs 0 the same cycle; halted re-raised -> dump restarts at addr 0.
REQ-038 SHALL cover a parameterised range: FIRST_REG=1, LAST_REG=5 with R1..R5 = 10,20,25,30,55 -> 5 beats, last on addr 5.
REQ-039 SHALL cover checksum: REG_DUMP_CHECKSUM_EN defined, FIRST_REG=1, LAST_REG=3, R1..R3 = 10,20,25 -> extra beat data 0x00000007 with dout_csum=1 and dout_last=1.
REQ-040 SHALL cover halted glitches: halted falls and re-rises during a dump -> no restart; done asserts once, then IDLE.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared debug-path types for the MIPS register dump block.
// Holds the dump FSM encoding and the register-file widths.
package mips_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [2:0] dump_state_t;

    localparam dump_state_t S_IDLE = 3'd0;
    localparam dump_state_t S_READ = 3'd1;
    localparam dump_state_t S_WAIT = 3'd2;
    localparam dump_state_t S_SEND = 3'd3;
    localparam dump_state_t S_DONE = 3'd4;

endpackage

// File: rtl/mips_reg_dump_if.sv
// Valid/ready beat stream carrying dumped register values.
// Optional checksum flag exists only with REG_DUMP_CHECKSUM_EN.
interface mips_reg_dump_if;
    import mips_dbg_pkg::*;

    logic                  dout_valid;
    logic                  dout_ready;
    logic [REG_ADDR_W-1:0] dout_addr;
    logic [WORD_W-1:0]     dout_data;
    logic                  dout_last;
`ifdef REG_DUMP_CHECKSUM_EN
    logic                  dout_csum;
`endif

    modport master (
        input  dout_ready,
        output dout_valid,
        output dout_addr,
        output dout_data,
        output dout_last
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        output dout_csum
`endif
    );

    modport slave (
        output dout_ready,
        input  dout_valid,
        input  dout_addr,
        input  dout_data,
        input  dout_last
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        input  dout_csum
`endif
    );

endinterface

// File: rtl/mips_reg_dump.sv
// Streams registers FIRST_REG..LAST_REG out after the pipeline halts.
// REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after LAST_REG.
module mips_reg_dump
    import mips_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  halted,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [WORD_W-1:0]     rf_rd_data,
    output logic                  busy,
    output logic                  done,
    mips_reg_dump_if.master       dout
);

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

    dump_state_t           r_state;
    logic                  r_halted_q;
    logic [REG_ADDR_W-1:0] r_idx;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0]     r_data;
    logic                  r_last;

    logic w_start;
    logic w_xfer;
    logic w_at_last;
    logic w_to_done;

    assign w_start   = halted & ~r_halted_q & (r_state == S_IDLE);
    assign w_xfer    = (r_state == S_SEND) & dout.dout_ready;
    assign w_at_last = (r_idx == LAST_A);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [WORD_W-1:0] r_csum;
    logic              r_csum_beat;
    logic              w_csum_load;

    assign w_csum_load = w_xfer & w_at_last & ~r_csum_beat;
    assign w_to_done   = r_csum_beat;
`else
    assign w_to_done   = w_at_last;
`endif

    // previous halted level, used to spot the rising edge
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_halted_q <= 1'b0;
        end else begin
            r_halted_q <= halted;
        end
    end

    // dump sequencer and register index; index moves only on transfer
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= FIRST_A;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_READ;
                        r_idx   <= FIRST_A;
                    end
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: r_state <= S_SEND;
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_to_done) begin
                            r_state <= S_DONE;
`ifdef REG_DUMP_CHECKSUM_EN
                        end else if (w_at_last) begin
                            r_state <= S_SEND;
`endif
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    if (!halted) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // beat payload: captured as read data lands, held through backpressure
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_addr <= r_idx;
            r_data <= rf_rd_data;
`ifdef REG_DUMP_CHECKSUM_EN
            r_last <= 1'b0;
        end else if (w_csum_load) begin
            r_addr <= '0;
            r_data <= r_csum;
            r_last <= 1'b1;
`else
            r_last <= w_at_last;
`endif
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // running XOR of dumped words plus the checksum-beat flag
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_csum      <= '0;
            r_csum_beat <= 1'b0;
        end else begin
            if (w_start) begin
                r_csum <= '0;
            end else if (r_state == S_WAIT) begin
                r_csum <= r_csum ^ rf_rd_data;
            end
            if (w_start) begin
                r_csum_beat <= 1'b0;
            end else if (w_csum_load) begin
                r_csum_beat <= 1'b1;
            end else if (w_xfer) begin
                r_csum_beat <= 1'b0;
            end
        end
    end

    assign dout.dout_csum = r_csum_beat;
`endif

    assign rf_rd_en        = (r_state == S_READ);
    assign rf_rd_addr      = rf_rd_en ? r_idx : '0;
    assign dout.dout_valid = (r_state == S_SEND);
    assign dout.dout_addr  = r_addr;
    assign dout.dout_data  = r_data;
    assign dout.dout_last  = r_last;
    assign busy            = (r_state == S_READ) |
                             (r_state == S_WAIT) |
                             (r_state == S_SEND);
    assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_mips_reg_dump.sv
// Directed bench for mips_reg_dump: three instances, scoreboard queue.
// Builds with or without REG_DUMP_CHECKSUM_EN.
module tb_mips_reg_dump;
    import mips_dbg_pkg::*;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
        logic        c;
    } exp_t;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n;
    logic        halted [3];
    logic        rdy    [3];
    logic        rd_en  [3];
    logic [4:0]  rd_adr [3];
    logic        busy   [3];
    logic        done   [3];
    logic        v      [3];
    logic [4:0]  addr   [3];
    logic [31:0] data   [3];
    logic        last   [3];
    logic        csum   [3];
    logic [31:0] mem    [3][32];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int FR = (g == 0) ? 0 : 1;
        localparam int LR = (g == 0) ? 31 : ((g == 1) ? 5 : 3);
        logic [31:0] r_rd;
        mips_reg_dump_if dif();
        mips_reg_dump #(.FIRST_REG(FR), .LAST_REG(LR)) u_dut (
            .clk1       (clk1),
            .rst_n      (rst_n),
            .halted     (halted[g]),
            .rf_rd_en   (rd_en[g]),
            .rf_rd_addr (rd_adr[g]),
            .rf_rd_data (r_rd),
            .busy       (busy[g]),
            .done       (done[g]),
            .dout       (dif.master)
        );
        always @(posedge clk1) r_rd <= mem[g][rd_adr[g]];
        assign dif.dout_ready = rdy[g];
        assign v[g]    = dif.dout_valid;
        assign addr[g] = dif.dout_addr;
        assign data[g] = dif.dout_data;
        assign last[g] = dif.dout_last;
`ifdef REG_DUMP_CHECKSUM_EN
        assign csum[g] = dif.dout_csum;
`else
        assign csum[g] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input int i, input int f, input int l);
        logic [31:0] x;
        exp_t e;
        x = '0;
        for (int k = f; k <= l; k++) begin
            e.a = 5'(k);
            e.d = mem[i][k];
            e.c = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            e.l = 1'b0;
`else
            e.l = (k == l);
`endif
            x = x ^ mem[i][k];
            q.push_back(e);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        e.a = 5'd0;
        e.d = x;
        e.l = 1'b1;
        e.c = 1'b1;
        q.push_back(e);
`endif
    endtask

    task automatic drain(input int i, input int stall_at,
                         input int stall_len);
        int   cyc;
        int   st;
        exp_t e;
        cyc = 0;
        st  = 0;
        while (q.size() > 0 && cyc < 3000) begin
            @(negedge clk1);
            cyc++;
            if (v[i] && int'(addr[i]) == stall_at && st < stall_len) begin
                rdy[i] = 1'b0;
                st++;
                chk("stall_valid", 32'(v[i]), 32'd1);
                chk("stall_addr", 32'(addr[i]), 32'(q[0].a));
                chk("stall_data", data[i], q[0].d);
            end else begin
                rdy[i] = 1'b1;
                if (v[i]) begin
                    e = q.pop_front();
                    chk("beat_addr", 32'(addr[i]), 32'(e.a));
                    chk("beat_data", data[i], e.d);
                    chk("beat_last", 32'(last[i]), 32'(e.l));
                    chk("beat_csum", 32'(csum[i]), 32'(e.c));
                end
            end
        end
        chk("beats_left", 32'(q.size()), 32'd0);
        chk("stall_cycles", 32'(st), 32'(stall_len));
        @(negedge clk1);
        rdy[i] = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            halted[i] = 1'b0;
            rdy[i]    = 1'b0;
            for (int k = 0; k < 32; k++) mem[i][k] = '0;
        end
        for (int k = 0; k < 32; k++) mem[0][k] = 32'(k * 3);
        mem[1][1] = 10; mem[1][2] = 20; mem[1][3] = 25;
        mem[1][4] = 30; mem[1][5] = 55;
        mem[2][1] = 10; mem[2][2] = 20; mem[2][3] = 25;

        repeat (2) @(negedge clk1);
        chk("rst_valid", 32'(v[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_rden", 32'(rd_en[0]), 0);
        chk("rst_addr", 32'(addr[0]), 0);
        chk("rst_data", data[0], 0);
        rst_n = 1'b1;
        @(negedge clk1);

        // full dump with backpressure on beat 7
        push_range(0, 0, 31);
        halted[0] = 1'b1;
        repeat (2) @(negedge clk1);
        chk("lat_valid_c2", 32'(v[0]), 0);
        chk("lat_busy_c2", 32'(busy[0]), 1);
        @(negedge clk1);
        chk("lat_valid_c3", 32'(v[0]), 1);
        chk("lat_first_addr", 32'(addr[0]), 0);
        drain(0, 7, 5);
        chk("full_done", 32'(done[0]), 1);
        chk("full_busy", 32'(busy[0]), 0);
        chk("full_valid", 32'(v[0]), 0);
        halted[0] = 1'b0;
        repeat (2) @(negedge clk1);
        chk("full_idle_done", 32'(done[0]), 0);

        // reset at beat 10, then restart from 0
        halted[0] = 1'b1;
        rdy[0] = 1'b1;
        cyc = 0;
        while (!(v[0] && addr[0] == 5'd10) && cyc < 1000) begin
            @(negedge clk1);
            cyc++;
        end
        chk("reach_beat10", 32'(addr[0]), 32'd10);
        rst_n = 1'b0;
        halted[0] = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(v[0]), 0);
        chk("mid_rst_busy", 32'(busy[0]), 0);
        chk("mid_rst_addr", 32'(addr[0]), 0);
        chk("mid_rst_data", data[0], 0);
        chk("mid_rst_last", 32'(last[0]), 0);
        chk("mid_rst_rden", 32'(rd_en[0]), 0);
        rdy[0] = 1'b0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("post_rst_busy", 32'(busy[0]), 0);
        push_range(0, 0, 31);
        halted[0] = 1'b1;
        drain(0, -1, 0);
        chk("restart_done", 32'(done[0]), 1);
        halted[0] = 1'b0;

        // range 1..5
        push_range(1, 1, 5);
        halted[1] = 1'b1;
        drain(1, -1, 0);
        chk("range_done", 32'(done[1]), 1);
        halted[1] = 1'b0;
        repeat (2) @(negedge clk1);
        chk("range_idle", 32'(done[1]), 0);

        // range 1..3 (checksum beat when enabled)
        push_range(2, 1, 3);
        halted[2] = 1'b1;
        drain(2, -1, 0);
        chk("cs_done", 32'(done[2]), 1);
        halted[2] = 1'b0;
        repeat (2) @(negedge clk1);
        chk("cs_idle", 32'(done[2]), 0);

        // halted falls mid-dump: finish, one DONE cycle, back to IDLE
        push_range(2, 1, 3);
        halted[2] = 1'b1;
        repeat (2) @(negedge clk1);
        halted[2] = 1'b0;
        drain(2, -1, 0);
        n = (done[2] === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk1);
            if (done[2] === 1'b1) n++;
        end
        chk("fall_done_cycles", 32'(n), 32'd1);
        chk("fall_busy", 32'(busy[2]), 0);

        // halted glitch mid-dump: no restart, done held once
        push_range(1, 1, 5);
        halted[1] = 1'b1;
        repeat (4) @(negedge clk1);
        halted[1] = 1'b0;
        repeat (2) @(negedge clk1);
        halted[1] = 1'b1;
        drain(1, -1, 0);
        n = 0;
        cyc = 0;
        rdy[1] = 1'b1;
        repeat (6) begin
            @(negedge clk1);
            if (done[1] === 1'b1) n++;
            if (v[1] === 1'b1 || busy[1] === 1'b1) cyc++;
        end
        chk("glitch_done_held", 32'(n), 32'd6);
        chk("glitch_no_restart", 32'(cyc), 32'd0);
        halted[1] = 1'b0;
        repeat (2) @(negedge clk1);
        chk("glitch_idle", 32'(done[1]), 0);
        rdy[1] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
